// File: rtl/fitness_pkg.sv
// rtl/fitness_pkg.sv - shared types and sizing helpers for the fitness sweep
package fitness_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    // Upper bounds for the column extractor; they cover every sensible
    // candidate size without making the helper parameterised.
    localparam int TT_MAX  = 1024;
    localparam int OUT_MAX = 32;

    function automatic int n_vec_of(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int score_w_of(input int n_out, input int n_in);
        return $clog2(n_out * (1 << n_in) + 1);
    endfunction

    // Gather bit j*n_vec+v for every output j: the expected output column
    // for input vector v.
    function automatic logic [OUT_MAX-1:0] target_col(
        input logic [TT_MAX-1:0] tt,
        input int                n_out,
        input int                n_vec,
        input int                v
    );
        logic [OUT_MAX-1:0] col;
        logic [TT_MAX-1:0]  sh;
        col = '0;
        for (int j = 0; j < OUT_MAX; j++) begin
            if (j < n_out) begin
                sh  = tt >> (j * n_vec + v);
                col = col | (OUT_MAX'(sh[0]) << j);
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/match_popcount.sv
// rtl/match_popcount.sv - XNOR match mask and population count of one sample
//
// Ports:
//   dut_out  in   N_OUT  sampled candidate outputs
//   col      in   N_OUT  expected outputs for the current vector
//   mask     out  N_OUT  1 where candidate output equals expectation
//   count    out  CW     number of set bits in mask
module match_popcount #(
    parameter int N_OUT = 4,
    parameter int CW    = $clog2(N_OUT + 1)
) (
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] col,
    output logic [N_OUT-1:0] mask,
    output logic [CW-1:0]    count
);

    assign mask = ~(dut_out ^ col);

    always_comb begin
        count = '0;
        for (int i = 0; i < N_OUT; i++) begin
            count = count + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/fitness_sweep.sv
// rtl/fitness_sweep.sv - truth-table sweep and match scoring of one evolved candidate
//
// Drives every input vector into the candidate, holds it SETTLE_CYCLES clocks,
// samples the outputs once and accumulates the number of bits matching the
// latched target truth table.
//
// Ports:
//   clk           in   1        clock, rising edge
//   rst_n         in   1        synchronous active-low reset
//   start         in   1        sweep request, accepted only in IDLE
//   target_tt     in   N_OUT*N_VEC  bit [j*N_VEC+v] = expected output j for vector v
//   dut_in        out  N_IN     vector driven into the candidate
//   dut_out       in   N_OUT    candidate outputs
//   busy          out  1        sweep in progress
//   done          out  1        one-cycle completion pulse
//   score         out  SW       matching bit count, held until next accept
//   perfect       out  1        score equals N_OUT*N_VEC
//   perout_score  out  N_OUT*PW per-output match counts (FITNESS_PEROUT_EN only)
//
// Build option: FITNESS_PEROUT_EN adds perout_score and its counters.
module fitness_sweep
    import fitness_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int N_OUT         = 4,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [N_OUT*(2**N_IN)-1:0]           target_tt,
    output logic [N_IN-1:0]                      dut_in,
    input  logic [N_OUT-1:0]                     dut_out,
    output logic                                 busy,
    output logic                                 done,
    output logic [score_w_of(N_OUT, N_IN)-1:0]   score,
    output logic                                 perfect
`ifdef FITNESS_PEROUT_EN
    ,
    output logic [N_OUT*$clog2((2**N_IN)+1)-1:0] perout_score
`endif
);

    localparam int N_VEC = n_vec_of(N_IN);
    localparam int TTW   = N_OUT * N_VEC;
    localparam int SW    = score_w_of(N_OUT, N_IN);
    localparam int CW    = $clog2(N_OUT + 1);
    localparam int SCW   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SW-1:0]   SCORE_MAX   = SW'(TTW);
    localparam logic [SCW-1:0]  SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(N_VEC - 1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SCW-1:0]    settle_q, settle_d;
    logic [TTW-1:0]    tt_q, tt_d;
    logic [SW-1:0]     score_q, score_d;

    logic [OUT_MAX-1:0] col_full;
    logic [N_OUT-1:0]   col;
    logic [N_OUT-1:0]   mask;
    logic [CW-1:0]      count;

    assign col_full = target_col(TT_MAX'(tt_q), N_OUT, N_VEC, int'(vec_q));
    assign col      = col_full[N_OUT-1:0];

    logic unused_col_hi;
    assign unused_col_hi = ^col_full[OUT_MAX-1:N_OUT];

    match_popcount #(.N_OUT(N_OUT), .CW(CW)) u_match (
        .dut_out (dut_out),
        .col     (col),
        .mask    (mask),
        .count   (count)
    );

`ifdef FITNESS_PEROUT_EN
    localparam int PW = $clog2(N_VEC + 1);
    logic [N_OUT-1:0][PW-1:0] perout_q, perout_d;
    assign perout_score = perout_q;
`else
    logic unused_mask;
    assign unused_mask = ^mask;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        tt_d     = tt_q;
        score_d  = score_q;
`ifdef FITNESS_PEROUT_EN
        perout_d = perout_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    tt_d     = target_tt;
                    vec_d    = '0;
                    score_d  = '0;
                    settle_d = SETTLE_LOAD;
`ifdef FITNESS_PEROUT_EN
                    perout_d = '0;
`endif
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                // Counter starts at SETTLE_CYCLES-1 so the vector is held
                // exactly SETTLE_CYCLES clocks before the sample cycle.
                if (settle_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q - SCW'(1);
                end
            end
            SAMPLE: begin
                score_d = score_q + SW'(count);
`ifdef FITNESS_PEROUT_EN
                for (int j = 0; j < N_OUT; j++) begin
                    perout_d[j] = perout_q[j] + PW'(mask[j]);
                end
`endif
                if (vec_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    vec_d    = vec_q + N_IN'(1);
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            tt_q     <= '0;
            score_q  <= '0;
`ifdef FITNESS_PEROUT_EN
            perout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            tt_q     <= tt_d;
            score_q  <= score_d;
`ifdef FITNESS_PEROUT_EN
            perout_q <= perout_d;
`endif
        end
    end

    // The driven vector is always the vector being scored.
    assign dut_in  = vec_q;
    assign busy    = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done    = (state_q == DONE);
    assign score   = score_q;
    assign perfect = (score_q == SCORE_MAX);

endmodule

// File: tb/tb_fitness_sweep.sv
// tb/tb_fitness_sweep.sv - scoreboard bench for fitness_sweep with a delayed gate-level candidate
module tb_fitness_sweep;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] target_tt;
    logic [3:0]  dut_in;
    wire  [3:0]  dut_out;
    logic        busy;
    logic        done;
    logic [6:0]  score;
    logic        perfect;
`ifdef FITNESS_PEROUT_EN
    logic [19:0] perout_score;
`endif

    always #50 clk = ~clk;

    fitness_sweep u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .target_tt    (target_tt),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .score        (score),
        .perfect      (perfect)
`ifdef FITNESS_PEROUT_EN
        ,
        .perout_score (perout_score)
`endif
    );

    // Candidate circuit: two gate levels, #50 per gate.
    wire n0, n1, n2;
    assign #50 n0 = dut_in[0] ^ dut_in[1];
    assign #50 n1 = dut_in[2] & dut_in[3];
    assign #50 n2 = dut_in[1] | dut_in[2];
    assign #50 dut_out[0] = n0 ^ dut_in[3];
    assign #50 dut_out[1] = n1 | dut_in[0];
    assign #50 dut_out[2] = ~(n2 & dut_in[0]);
    assign #50 dut_out[3] = n0 & n2;

    function automatic logic [3:0] ref_f(input logic [3:0] x);
        logic [3:0] y;
        y[0] = x[0] ^ x[1] ^ x[3];
        y[1] = (x[2] & x[3]) | x[0];
        y[2] = ~((x[1] | x[2]) & x[0]);
        y[3] = (x[0] ^ x[1]) & (x[1] | x[2]);
        return y;
    endfunction

    function automatic logic [63:0] exact_tt();
        logic [63:0] tt;
        logic [3:0]  y;
        logic [3:0]  ys;
        tt = '0;
        for (int v = 0; v < 16; v++) begin
            y = ref_f(4'(v));
            for (int j = 0; j < 4; j++) begin
                ys = y >> j;
                tt = tt | (64'(ys[0]) << (j * 16 + v));
            end
        end
        return tt;
    endfunction

    typedef struct packed {
        logic [6:0]  score;
        logic        perfect;
        logic [19:0] perout;
    } exp_t;

    function automatic exp_t mk_exp(input int s, input int p3, input int p2,
                                    input int p1, input int p0);
        exp_t e;
        e.score   = 7'(s);
        e.perfect = (s == 64);
        e.perout  = {5'(p3), 5'(p2), 5'(p1), 5'(p0)};
        return e;
    endfunction

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("score", 64'(score), 64'(e.score));
                check("perfect", 64'(perfect), 64'(e.perfect));
`ifdef FITNESS_PEROUT_EN
                check("perout_score", 64'(perout_score), 64'(e.perout));
`endif
            end
        end
    end

    task automatic start_sweep(input logic [63:0] tt, input exp_t e, input bit push_it);
        @(negedge clk);
        target_tt = tt;
        start     = 1'b1;
        if (push_it) sb.push_back(e);
        @(posedge clk);
        #1;
        start     = 1'b0;
        target_tt = ~tt;
    endtask

    task automatic wait_done(output int lat, input bit do_walk, output int walk_err);
        bit got;
        got      = 1'b0;
        lat      = 0;
        walk_err = 0;
        while (!got && lat < 400) begin
            @(negedge clk);
            lat++;
            if (do_walk && lat <= 144 && dut_in !== 4'((lat - 1) / 9)) walk_err++;
            if (done === 1'b1) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim time exceeded checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ex;
        int          lat;
        int          werr;

        rst_n     = 1'b0;
        start     = 1'b0;
        target_tt = '0;
        ex        = exact_tt();
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_perfect", 64'(perfect), 64'd0);
        check("rst_dut_in", 64'(dut_in), 64'd0);
        rst_n = 1'b1;

        // exact table
        start_sweep(ex, mk_exp(64, 16, 16, 16, 16), 1'b1);
        wait_done(lat, 1'b0, werr);
        check("lat_exact", 64'(lat), 64'd145);
        check("busy_in_done", 64'(busy), 64'd0);

        // inverse table
        start_sweep(~ex, mk_exp(0, 0, 0, 0, 0), 1'b1);
        wait_done(lat, 1'b0, werr);
        check("lat_inverse", 64'(lat), 64'd145);

        // single flipped bit, vector walk
        start_sweep(ex ^ (64'd1 << 5), mk_exp(63, 16, 16, 16, 15), 1'b1);
        wait_done(lat, 1'b1, werr);
        check("lat_flip1", 64'(lat), 64'd145);
        check("dut_in_walk_errors", 64'(werr), 64'd0);
        check("dut_in_last", 64'(dut_in), 64'd15);

        // start held high through the sweep
        @(negedge clk);
        target_tt = ex;
        start     = 1'b1;
        sb.push_back(mk_exp(64, 16, 16, 16, 16));
        sb.push_back(mk_exp(64, 16, 16, 16, 16));
        @(posedge clk);
        #1;
        wait_done(lat, 1'b0, werr);
        check("lat_held_start", 64'(lat), 64'd145);
        check("held_busy_in_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_busy_in_idle", 64'(busy), 64'd0);
        @(negedge clk);
        check("held_rearm_from_idle", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(lat, 1'b0, werr);
        check("lat_second_sweep", 64'(lat), 64'd144);

        // reset mid-sweep
        start_sweep(ex, mk_exp(64, 16, 16, 16, 16), 1'b0);
        repeat (39) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_dut_in", 64'(dut_in), 64'd0);
        check("abort_score", 64'(score), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_reset_ignored", 64'(busy), 64'd0);
        repeat (200) @(negedge clk);
        start_sweep(ex, mk_exp(64, 16, 16, 16, 16), 1'b1);
        wait_done(lat, 1'b0, werr);
        check("lat_after_abort", 64'(lat), 64'd145);

        // three flips on output1
        start_sweep(ex ^ (64'd1 << 18) ^ (64'd1 << 23) ^ (64'd1 << 27),
                    mk_exp(61, 16, 16, 13, 16), 1'b1);
        wait_done(lat, 1'b0, werr);
        check("lat_out1_flips", 64'(lat), 64'd145);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
